mem_access_stage: RTL and testbench

Memory-access (MEM) stage of the five-stage MIPS pipeline: sits between the execute stage and the write-back stage. It owns the data memory and performs byte/halfword/word loads and stores with sign or zero extension. It registers the load result and all write-back sidebands into the MEM/WB pipeline register. A debug read port lets the debug unit inspect data memory while the pipeline is stepped or halted.

---
 rtl/mem_access_stage.sv | 177 +++++++++++++++++
 tb/tb_mem_access_stage.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// mem_access_stage: the memory-access stage of a five-stage MIPS pipeline.
// It owns the data memory and performs byte, halfword and word loads and stores.
// The load result and the write-back sidebands are registered into MEM/WB.
//
// Ports:
//   i_clock, i_reset     clock and synchronous active-low reset
//   i_enable             pipeline advance; 0 freezes memory writes and MEM/WB
//   i_mem_read/_write    load / store strobes
//   i_size, i_signed     access size (00 B, 01 H, 1x W) and load extension
//   i_alu_result         effective byte address (also passed through)
//   i_write_data         store data
//   i_pc, i_inm_ext, i_mem_to_reg, i_reg_write, i_rd   write-back sidebands
//   i_debug_addr         debug word address
//   o_mem_data           registered, extended load data
//   o_misaligned         registered misaligned-access flag
//   o_alu_result .. o_rd registered pass-through sidebands
//   o_debug_data         combinational word at i_debug_addr
module mem_access_stage #(
  parameter int unsigned NB_DATA       = 32,
  parameter int unsigned NB_ADDR       = 7,
  parameter int unsigned NB_PC         = 7,
  parameter int unsigned NB_REG        = 5,
  parameter int unsigned NB_MEM_TO_REG = 2
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  input  logic                     i_enable,
  input  logic                     i_mem_read,
  input  logic                     i_mem_write,
  input  logic [1:0]               i_size,
  input  logic                     i_signed,
  input  logic [NB_DATA-1:0]       i_alu_result,
  input  logic [NB_DATA-1:0]       i_write_data,
  input  logic [NB_PC-1:0]         i_pc,
  input  logic [NB_DATA-1:0]       i_inm_ext,
  input  logic [NB_MEM_TO_REG-1:0] i_mem_to_reg,
  input  logic                     i_reg_write,
  input  logic [NB_REG-1:0]        i_rd,
  input  logic [NB_ADDR-1:0]       i_debug_addr,
  output logic [NB_DATA-1:0]       o_mem_data,
  output logic [NB_DATA-1:0]       o_alu_result,
  output logic [NB_PC-1:0]         o_pc,
  output logic [NB_DATA-1:0]       o_inm_ext,
  output logic [NB_MEM_TO_REG-1:0] o_mem_to_reg,
  output logic                     o_reg_write,
  output logic [NB_REG-1:0]        o_rd,
  output logic                     o_misaligned,
  output logic [NB_DATA-1:0]       o_debug_data
);

  localparam int unsigned Words = 2 ** NB_ADDR;

  logic [NB_DATA-1:0] mem_q [Words];

  logic [NB_ADDR-1:0] word_idx;
  logic [1:0]         lane;
  logic               is_byte;
  logic               is_half;
  logic               is_word;
  logic               addr_misaligned;
  logic [NB_DATA-1:0] rd_word;
  logic [7:0]         byte_sel;
  logic [15:0]        half_sel;
  logic [NB_DATA-1:0] load_ext;
  logic [NB_DATA-1:0] wr_word;
  logic               store_en;

  logic [NB_DATA-1:0]       mem_data_d, mem_data_q;
  logic                     misaligned_d, misaligned_q;
  logic [NB_DATA-1:0]       alu_result_q;
  logic [NB_PC-1:0]         pc_q;
  logic [NB_DATA-1:0]       inm_ext_q;
  logic [NB_MEM_TO_REG-1:0] mem_to_reg_q;
  logic                     reg_write_q;
  logic [NB_REG-1:0]        rd_q;

  // Upper address bits are dropped, so accesses wrap modulo the memory size.
  assign word_idx = i_alu_result[NB_ADDR+1:2];
  assign lane     = i_alu_result[1:0];

  // Size 10 is treated as a word access.
  assign is_byte = (i_size == 2'b00);
  assign is_half = (i_size == 2'b01);
  assign is_word = i_size[1];

  assign addr_misaligned = (is_half && lane[0]) || (is_word && (lane != 2'b00));

  assign rd_word      = mem_q[word_idx];
  assign o_debug_data = mem_q[i_debug_addr];

  // Lane selection for loads (little-endian, lane 0 = bits 7:0).
  always_comb begin
    byte_sel = rd_word[7:0];
    case (lane)
      2'b00:   byte_sel = rd_word[7:0];
      2'b01:   byte_sel = rd_word[15:8];
      2'b10:   byte_sel = rd_word[23:16];
      default: byte_sel = rd_word[31:24];
    endcase
    half_sel = lane[1] ? rd_word[31:16] : rd_word[15:0];
  end

  always_comb begin
    load_ext = rd_word;
    if (is_byte) begin
      load_ext = {{(NB_DATA-8){i_signed & byte_sel[7]}}, byte_sel};
    end else if (is_half) begin
      load_ext = {{(NB_DATA-16){i_signed & half_sel[15]}}, half_sel};
    end
  end

  // Merge store data into the current word so untouched lanes are preserved.
  always_comb begin
    wr_word = rd_word;
    if (is_byte) begin
      case (lane)
        2'b00:   wr_word[7:0]   = i_write_data[7:0];
        2'b01:   wr_word[15:8]  = i_write_data[7:0];
        2'b10:   wr_word[23:16] = i_write_data[7:0];
        default: wr_word[31:24] = i_write_data[7:0];
      endcase
    end else if (is_half) begin
      if (lane[1]) begin
        wr_word[31:16] = i_write_data[15:0];
      end else begin
        wr_word[15:0] = i_write_data[15:0];
      end
    end else begin
      wr_word = i_write_data;
    end
  end

  // Reset takes priority over a pending store; a read+write combo acts as a store.
  assign store_en = i_reset && i_enable && i_mem_write && !addr_misaligned;

  assign mem_data_d   = (i_mem_read && !i_mem_write && !addr_misaligned) ? load_ext : '0;
  assign misaligned_d = (i_mem_read || i_mem_write) && addr_misaligned;

  // Memory contents survive reset.
  always_ff @(posedge i_clock) begin
    if (store_en) begin
      mem_q[word_idx] <= wr_word;
    end
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      mem_data_q   <= '0;
      misaligned_q <= 1'b0;
      alu_result_q <= '0;
      pc_q         <= '0;
      inm_ext_q    <= '0;
      mem_to_reg_q <= '0;
      reg_write_q  <= 1'b0;
      rd_q         <= '0;
    end else if (i_enable) begin
      mem_data_q   <= mem_data_d;
      misaligned_q <= misaligned_d;
      alu_result_q <= i_alu_result;
      pc_q         <= i_pc;
      inm_ext_q    <= i_inm_ext;
      mem_to_reg_q <= i_mem_to_reg;
      reg_write_q  <= i_reg_write;
      rd_q         <= i_rd;
    end
  end

  assign o_mem_data   = mem_data_q;
  assign o_misaligned = misaligned_q;
  assign o_alu_result = alu_result_q;
  assign o_pc         = pc_q;
  assign o_inm_ext    = inm_ext_q;
  assign o_mem_to_reg = mem_to_reg_q;
  assign o_reg_write  = reg_write_q;
  assign o_rd         = rd_q;

endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  size;
  logic        sgn;
  logic [31:0] alu_result;
  logic [31:0] write_data;
  logic [6:0]  pc;
  logic [31:0] inm_ext;
  logic [1:0]  mem_to_reg;
  logic        reg_write;
  logic [4:0]  rd;
  logic [6:0]  debug_addr;
  logic [31:0] o_mem_data;
  logic [31:0] o_alu_result;
  logic [6:0]  o_pc;
  logic [31:0] o_inm_ext;
  logic [1:0]  o_mem_to_reg;
  logic        o_reg_write;
  logic [4:0]  o_rd;
  logic        o_misaligned;
  logic [31:0] o_debug_data;

  int checks;
  int failures;

  mem_access_stage dut (
    .i_clock      (clk),
    .i_reset      (rst_n),
    .i_enable     (en),
    .i_mem_read   (mem_read),
    .i_mem_write  (mem_write),
    .i_size       (size),
    .i_signed     (sgn),
    .i_alu_result (alu_result),
    .i_write_data (write_data),
    .i_pc         (pc),
    .i_inm_ext    (inm_ext),
    .i_mem_to_reg (mem_to_reg),
    .i_reg_write  (reg_write),
    .i_rd         (rd),
    .i_debug_addr (debug_addr),
    .o_mem_data   (o_mem_data),
    .o_alu_result (o_alu_result),
    .o_pc         (o_pc),
    .o_inm_ext    (o_inm_ext),
    .o_mem_to_reg (o_mem_to_reg),
    .o_reg_write  (o_reg_write),
    .o_rd         (o_rd),
    .o_misaligned (o_misaligned),
    .o_debug_data (o_debug_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [6:0]  dbg;
    logic [31:0] exp_data;
    logic        exp_mis;
    logic [31:0] exp_dbg;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic w, logic [1:0] s, logic sg, logic [31:0] a,
                              logic [31:0] wd, logic [6:0] d, logic [31:0] ed, logic em,
                              logic [31:0] edb);
    vec_t v;
    v.rd = r; v.wr = w; v.size = s; v.sgn = sg; v.addr = a; v.wdata = wd; v.dbg = d;
    v.exp_data = ed; v.exp_mis = em; v.exp_dbg = edb;
    return v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive_mem(logic r, logic w, logic [1:0] s, logic sg, logic [31:0] a,
                           logic [31:0] wd, logic [6:0] d);
    mem_read = r; mem_write = w; size = s; sgn = sg; alu_result = a; write_data = wd;
    debug_addr = d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0; en = 1'b1;
    drive_mem(1'b0, 1'b0, 2'b11, 1'b0, 32'h0, 32'h0, 7'd0);
    pc = '0; inm_ext = '0; mem_to_reg = '0; reg_write = 1'b0; rd = '0;

    //       rd    wr    size   sgn   addr        wdata         dbg    exp_data      mis   exp_dbg
    vecs.push_back(mk(1'b0, 1'b1, 2'b11, 1'b0, 32'h00, 32'hA5A5A5A5, 7'd0, 32'h0, 1'b0, 32'hA5A5A5A5));
    vecs.push_back(mk(1'b0, 1'b1, 2'b11, 1'b0, 32'h10, 32'hDEADBEEF, 7'd4, 32'h0, 1'b0, 32'hDEADBEEF));
    vecs.push_back(mk(1'b1, 1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 7'd4, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF));
    vecs.push_back(mk(1'b0, 1'b1, 2'b11, 1'b0, 32'h10, 32'h11223344, 7'd4, 32'h0, 1'b0, 32'h11223344));
    vecs.push_back(mk(1'b0, 1'b1, 2'b00, 1'b0, 32'h13, 32'hFFFFFF80, 7'd4, 32'h0, 1'b0, 32'h80223344));
    vecs.push_back(mk(1'b1, 1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 7'd4, 32'hFFFFFF80, 1'b0, 32'h80223344));
    vecs.push_back(mk(1'b1, 1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 7'd4, 32'h00000080, 1'b0, 32'h80223344));
    vecs.push_back(mk(1'b1, 1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 7'd4, 32'hFFFF8022, 1'b0, 32'h80223344));
    vecs.push_back(mk(1'b1, 1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 7'd4, 32'h00008022, 1'b0, 32'h80223344));
    vecs.push_back(mk(1'b1, 1'b0, 2'b01, 1'b1, 32'h10, 32'h0, 7'd4, 32'h00003344, 1'b0, 32'h80223344));
    vecs.push_back(mk(1'b1, 1'b0, 2'b00, 1'b1, 32'h11, 32'h0, 7'd4, 32'h00000033, 1'b0, 32'h80223344));
    vecs.push_back(mk(1'b0, 1'b1, 2'b01, 1'b0, 32'h10, 32'h1234ABCD, 7'd4, 32'h0, 1'b0, 32'h8022ABCD));
    vecs.push_back(mk(1'b1, 1'b0, 2'b01, 1'b1, 32'h10, 32'h0, 7'd4, 32'hFFFFABCD, 1'b0, 32'h8022ABCD));
    vecs.push_back(mk(1'b0, 1'b1, 2'b11, 1'b0, 32'h20, 32'h55667788, 7'd8, 32'h0, 1'b0, 32'h55667788));
    vecs.push_back(mk(1'b0, 1'b1, 2'b11, 1'b0, 32'h22, 32'hCAFEF00D, 7'd8, 32'h0, 1'b1, 32'h55667788));
    vecs.push_back(mk(1'b1, 1'b0, 2'b01, 1'b1, 32'h21, 32'h0, 7'd8, 32'h0, 1'b1, 32'h55667788));
    vecs.push_back(mk(1'b1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 7'd8, 32'h55667788, 1'b0, 32'h55667788));
    vecs.push_back(mk(1'b1, 1'b0, 2'b01, 1'b1, 32'h22, 32'h0, 7'd8, 32'h00005566, 1'b0, 32'h55667788));
    vecs.push_back(mk(1'b1, 1'b1, 2'b11, 1'b0, 32'h20, 32'h01020304, 7'd8, 32'h0, 1'b0, 32'h01020304));
    vecs.push_back(mk(1'b0, 1'b0, 2'b11, 1'b0, 32'h23, 32'hFFFFFFFF, 7'd8, 32'h0, 1'b0, 32'h01020304));
    vecs.push_back(mk(1'b0, 1'b1, 2'b11, 1'b0, 32'h210, 32'h0BADCAFE, 7'd4, 32'h0, 1'b0, 32'h0BADCAFE));
    vecs.push_back(mk(1'b1, 1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 7'd4, 32'h0BADCAFE, 1'b0, 32'h0BADCAFE));
    vecs.push_back(mk(1'b0, 1'b1, 2'b00, 1'b0, 32'h21, 32'h0000007F, 7'd8, 32'h0, 1'b0, 32'h01027F04));
    vecs.push_back(mk(1'b0, 1'b1, 2'b01, 1'b0, 32'h23, 32'h0000FFFF, 7'd8, 32'h0, 1'b1, 32'h01027F04));

    // Reset from time zero.
    step();
    step();
    check("rst_mem_data", o_mem_data, 32'h0);
    check("rst_misaligned", {31'h0, o_misaligned}, 32'h0);
    check("rst_alu_result", o_alu_result, 32'h0);
    check("rst_sidebands", {o_inm_ext[24:0], o_pc}, 32'h0);
    check("rst_ctrl", {24'h0, o_mem_to_reg, o_reg_write, o_rd}, 32'h0);

    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive_mem(vecs[i].rd, vecs[i].wr, vecs[i].size, vecs[i].sgn, vecs[i].addr,
                vecs[i].wdata, vecs[i].dbg);
      pc = 7'(i);
      step();
      check($sformatf("v%0d_mem_data", i), o_mem_data, vecs[i].exp_data);
      check($sformatf("v%0d_misaligned", i), {31'h0, o_misaligned}, {31'h0, vecs[i].exp_mis});
      check($sformatf("v%0d_debug", i), o_debug_data, vecs[i].exp_dbg);
      check($sformatf("v%0d_alu_result", i), o_alu_result, vecs[i].addr);
      check($sformatf("v%0d_pc", i), {25'h0, o_pc}, i);
    end

    // Freeze: load through the wrapped alias so o_alu_result differs from the later store.
    @(negedge clk);
    drive_mem(1'b1, 1'b0, 2'b11, 1'b0, 32'h210, 32'h0, 7'd4);
    pc = 7'h11;
    step();
    check("frz_pre_data", o_mem_data, 32'h0BADCAFE);
    @(negedge clk);
    en = 1'b0;
    drive_mem(1'b0, 1'b1, 2'b11, 1'b0, 32'h10, 32'h12345678, 7'd4);
    pc = 7'h55;
    #1;
    check("frz_dbg_pending", o_debug_data, 32'h0BADCAFE);
    step();
    check("frz_mem_unchanged", o_debug_data, 32'h0BADCAFE);
    check("frz_hold_data", o_mem_data, 32'h0BADCAFE);
    check("frz_hold_alu", o_alu_result, 32'h210);
    check("frz_hold_pc", {25'h0, o_pc}, 32'h11);
    @(negedge clk);
    en = 1'b1;
    #1;
    check("reen_dbg_old", o_debug_data, 32'h0BADCAFE);
    step();
    check("reen_dbg_new", o_debug_data, 32'h12345678);
    check("reen_data", o_mem_data, 32'h0);
    check("reen_alu", o_alu_result, 32'h10);
    check("reen_pc", {25'h0, o_pc}, 32'h55);

    // Pass-through with a load so every registered output is nonzero before reset.
    @(negedge clk);
    drive_mem(1'b1, 1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 7'd0);
    pc = 7'h2A; inm_ext = 32'h12340000; mem_to_reg = 2'b11; rd = 5'd31; reg_write = 1'b1;
    step();
    check("pt_pc", {25'h0, o_pc}, 32'h2A);
    check("pt_inm", o_inm_ext, 32'h12340000);
    check("pt_mem_to_reg", {30'h0, o_mem_to_reg}, 32'h3);
    check("pt_rd", {27'h0, o_rd}, 32'd31);
    check("pt_reg_write", {31'h0, o_reg_write}, 32'h1);
    check("pt_mem_data", o_mem_data, 32'h12345678);

    // Misaligned flag set, then reset with a store pending to word 0.
    @(negedge clk);
    drive_mem(1'b1, 1'b0, 2'b01, 1'b0, 32'h21, 32'h0, 7'd0);
    step();
    check("pre_rst_mis", {31'h0, o_misaligned}, 32'h1);
    @(negedge clk);
    rst_n = 1'b0;
    drive_mem(1'b0, 1'b1, 2'b11, 1'b0, 32'h00, 32'hFFFFFFFF, 7'd0);
    step();
    check("rst2_mem_data", o_mem_data, 32'h0);
    check("rst2_misaligned", {31'h0, o_misaligned}, 32'h0);
    check("rst2_alu", o_alu_result, 32'h0);
    check("rst2_inm", o_inm_ext, 32'h0);
    check("rst2_ctrl", {18'h0, o_pc, o_mem_to_reg, o_reg_write, o_rd}, 32'h0);
    check("rst2_mem_kept", o_debug_data, 32'hA5A5A5A5);

    @(negedge clk);
    rst_n = 1'b1;
    drive_mem(1'b0, 1'b0, 2'b11, 1'b0, 32'h0, 32'h0, 7'd0);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
